// File: rtl/ins_exec_rvi_i_comp_seq.sv
// RISC-V OP-IMM / OP-IMM-32 executor with valid/ready handshakes on both sides.
// Shifts use a barrel shifter (SHIFT_STEP=0) or run SHIFT_STEP bits per cycle.
//  state | meaning
//  IDLE  | accept or drain
//  SHIFT | iterative shift running
//  HOLD  | result valid, waiting on out_ready
module ins_exec_rvi_i_comp_seq #(
  parameter int XLEN       = 32,
  parameter bit EN_W       = 1'b1,
  parameter int SHIFT_STEP = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [6:0]      ins_dec_op,
  input  logic [2:0]      ins_dec_funct3,
  input  logic [XLEN-1:0] reg_rs1_val,
  input  logic [XLEN-1:0] imm_ext_ext,
  input  logic [4:0]      reg_rd,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            reg_w_op,
  output logic [4:0]      reg_w_reg_idx,
  output logic [XLEN-1:0] reg_w_reg_val,
  output logic            illegal,
  output logic            busy
);

  localparam int SW = $clog2(XLEN);
  localparam bit W_EN = EN_W && (XLEN == 64);
  localparam logic [SW-1:0] STEP = SW'(SHIFT_STEP);
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_IMM_32 = 7'b0011011;
  localparam logic [1:0] K_SLL = 2'd0;
  localparam logic [1:0] K_SRL = 2'd1;
  localparam logic [1:0] K_SRA = 2'd2;

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] res_q, res_d;
  logic [4:0]      idx_q, idx_d;
  logic            we_q, we_d;
  logic            ill_q, ill_d;
  logic [SW-1:0]   cnt_q, cnt_d;
  logic [1:0]      kind_q, kind_d;
  logic            w_q, w_d;

  logic [XLEN-1:0] a_val, a_opnd, shv;
  logic [SW-1:0]   a_amt, step;
  logic [1:0]      a_kind;
  logic            a_w, a_shift, a_ill, a_bub, a_iter, a_we;
  logic [4:0]      a_idx;
  logic            accept;

  function automatic logic [XLEN-1:0] shift_fn(input logic [XLEN-1:0] v,
                                               input logic [1:0] k,
                                               input logic [SW-1:0] n);
    case (k)
      K_SRL:   shift_fn = v >> n;
      K_SRA:   shift_fn = $signed(v) >>> n;
      default: shift_fn = v << n;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] x);
    sext32 = XLEN'($signed(x));
  endfunction

  // Decode and evaluate the presented instruction; only used on accept.
  always_comb begin
    a_val   = '0;
    a_opnd  = reg_rs1_val;
    a_amt   = imm_ext_ext[SW-1:0];
    a_kind  = K_SLL;
    a_w     = 1'b0;
    a_shift = 1'b0;
    a_ill   = 1'b0;
    a_bub   = 1'b0;
    if (ins_dec_op == OP_IMM) begin
      case (ins_dec_funct3)
        3'd0: a_val = reg_rs1_val + imm_ext_ext;
        3'd2: a_val = {{(XLEN-1){1'b0}}, $signed(reg_rs1_val) < $signed(imm_ext_ext)};
        3'd3: a_val = {{(XLEN-1){1'b0}}, reg_rs1_val < imm_ext_ext};
        3'd4: a_val = reg_rs1_val ^ imm_ext_ext;
        3'd6: a_val = reg_rs1_val | imm_ext_ext;
        3'd1: begin
          a_shift = 1'b1;
          a_ill   = (imm_ext_ext[11:SW] != '0);
        end
        3'd5: begin
          a_shift = 1'b1;
          if (imm_ext_ext[11:SW] == '0)
            a_kind = K_SRL;
          else if (imm_ext_ext[10] && ({imm_ext_ext[11], imm_ext_ext[9:SW]} == '0))
            a_kind = K_SRA;
          else
            a_ill = 1'b1;
        end
        default: a_val = reg_rs1_val & imm_ext_ext;
      endcase
    end else if (ins_dec_op == OP_IMM_32) begin
      if (!W_EN) begin
        a_ill = 1'b1;
      end else begin
        a_w   = 1'b1;
        a_amt = SW'(imm_ext_ext[4:0]);
        case (ins_dec_funct3)
          3'd0: a_val = sext32(reg_rs1_val[31:0] + imm_ext_ext[31:0]);
          3'd1: begin
            a_shift = 1'b1;
            a_ill   = (imm_ext_ext[11:5] != 7'h00);
          end
          3'd5: begin
            a_shift = 1'b1;
            if (imm_ext_ext[11:5] == 7'h00) begin
              a_kind = K_SRL;
              a_opnd = XLEN'(reg_rs1_val[31:0]);
            end else if (imm_ext_ext[11:5] == 7'h20) begin
              a_kind = K_SRA;
              a_opnd = sext32(reg_rs1_val[31:0]);
            end else begin
              a_ill = 1'b1;
            end
          end
          default: a_ill = 1'b1;
        endcase
      end
    end else begin
      a_bub = 1'b1;
    end
    // In iterative mode this path only ever sees shamt=0, so no barrel is built.
    if (a_shift) begin
      a_val = (SHIFT_STEP == 0) ? shift_fn(a_opnd, a_kind, a_amt) : a_opnd;
      if (a_w) a_val = sext32(a_val[31:0]);
    end
    if (a_ill || a_bub) a_val = '0;
    a_iter = a_shift && !a_ill && (SHIFT_STEP != 0) && (a_amt != '0);
    a_we   = !a_bub && !a_ill && (reg_rd != 5'd0);
    a_idx  = a_bub ? 5'd0 : reg_rd;
  end

  assign in_ready = !rst && ((state_q == IDLE) || ((state_q == HOLD) && out_ready));
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    idx_d   = idx_q;
    we_d    = we_q;
    ill_d   = ill_q;
    cnt_d   = cnt_q;
    kind_d  = kind_q;
    w_d     = w_q;
    step    = (cnt_q > STEP) ? STEP : cnt_q;
    shv     = shift_fn(res_q, kind_q, step);
    case (state_q)
      SHIFT: begin
        cnt_d = cnt_q - step;
        res_d = shv;
        if (cnt_d == '0) begin
          state_d = HOLD;
          if (w_q) res_d = sext32(shv[31:0]);
        end
      end
      HOLD:    if (out_ready) state_d = IDLE;
      default: ;
    endcase
    if (accept) begin
      idx_d   = a_idx;
      we_d    = a_we;
      ill_d   = a_ill;
      cnt_d   = a_amt;
      kind_d  = a_kind;
      w_d     = a_w;
      state_d = a_iter ? SHIFT : HOLD;
      res_d   = a_iter ? a_opnd : a_val;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      res_q   <= '0;
      idx_q   <= '0;
      we_q    <= 1'b0;
      ill_q   <= 1'b0;
      cnt_q   <= '0;
      kind_q  <= K_SLL;
      w_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      idx_q   <= idx_d;
      we_q    <= we_d;
      ill_q   <= ill_d;
      cnt_q   <= cnt_d;
      kind_q  <= kind_d;
      w_q     <= w_d;
    end
  end

  // The working register doubles as the shifter, so outputs are gated by HOLD.
  assign out_valid     = (state_q == HOLD);
  assign busy          = (state_q == SHIFT);
  assign reg_w_op      = out_valid && we_q;
  assign illegal       = out_valid && ill_q;
  assign reg_w_reg_idx = out_valid ? idx_q : 5'd0;
  assign reg_w_reg_val = out_valid ? res_q : '0;

endmodule

// File: tb/tb_ins_exec_rvi_i_comp_seq.sv
// Bench for ins_exec_rvi_i_comp_seq: a 32-bit iterative (step 4) instance and a
// 64-bit barrel instance with W ops, checked against an arithmetic reference model.
module tb_ins_exec_rvi_i_comp_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, iv32, iv64, ordy, sel;
  logic [6:0]  op;
  logic [2:0]  f3;
  logic [63:0] rs1;
  logic [11:0] imm12;
  logic [4:0]  rd;
  logic [63:0] imm_x;
  assign imm_x = {{52{imm12[11]}}, imm12};

  logic ir32, ov32, we32, il32, bz32;
  logic [4:0]  ix32;
  logic [31:0] v32;
  logic ir64, ov64, we64, il64, bz64;
  logic [4:0]  ix64;
  logic [63:0] v64;

  ins_exec_rvi_i_comp_seq #(.XLEN(32), .EN_W(1'b1), .SHIFT_STEP(4)) u_d32 (
    .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32),
    .ins_dec_op(op), .ins_dec_funct3(f3), .reg_rs1_val(rs1[31:0]),
    .imm_ext_ext(imm_x[31:0]), .reg_rd(rd), .out_valid(ov32), .out_ready(ordy),
    .reg_w_op(we32), .reg_w_reg_idx(ix32), .reg_w_reg_val(v32),
    .illegal(il32), .busy(bz32));

  ins_exec_rvi_i_comp_seq #(.XLEN(64), .EN_W(1'b1), .SHIFT_STEP(0)) u_d64 (
    .clk(clk), .rst(rst), .in_valid(iv64), .in_ready(ir64),
    .ins_dec_op(op), .ins_dec_funct3(f3), .reg_rs1_val(rs1),
    .imm_ext_ext(imm_x), .reg_rd(rd), .out_valid(ov64), .out_ready(ordy),
    .reg_w_op(we64), .reg_w_reg_idx(ix64), .reg_w_reg_val(v64),
    .illegal(il64), .busy(bz64));

  logic        o_ir, o_ov, o_we, o_il, o_bz;
  logic [4:0]  o_ix;
  logic [63:0] o_v;
  assign o_ir = sel ? ir64 : ir32;
  assign o_ov = sel ? ov64 : ov32;
  assign o_we = sel ? we64 : we32;
  assign o_il = sel ? il64 : il32;
  assign o_bz = sel ? bz64 : bz32;
  assign o_ix = sel ? ix64 : ix32;
  assign o_v  = sel ? v64 : {32'd0, v32};

  typedef struct packed {
    logic        we;
    logic [4:0]  idx;
    logic [63:0] val;
    logic        ill;
    int          lat;
  } exp_t;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] sx(input logic [31:0] x);
    return {{32{x[31]}}, x};
  endfunction

  function automatic exp_t model(input int xlen, input int stp, input logic [6:0] o,
                                 input logic [2:0] f, input logic [63:0] r,
                                 input logic [11:0] i, input logic [4:0] d);
    exp_t e;
    logic [63:0] mask, a, b, v;
    longint sa, sb;
    int sw, up, sh;
    bit ill, bub, shf;
    mask = (xlen == 32) ? 64'h0000_0000_FFFF_FFFF : '1;
    a    = r & mask;
    b    = {{52{i[11]}}, i} & mask;
    sa   = (xlen == 32) ? longint'($signed(r[31:0])) : longint'(r);
    sb   = longint'($signed(i));
    sw   = (xlen == 32) ? 5 : 6;
    up   = int'(i) >> sw;
    sh   = int'(i) & (xlen - 1);
    ill = 0; bub = 0; shf = 0; v = '0;
    if (o == 7'h13) begin
      case (f)
        3'd0: v = (a + b) & mask;
        3'd1: if (up == 0) begin shf = 1; v = (a << sh) & mask; end else ill = 1;
        3'd2: v = (sa < sb) ? 64'd1 : 64'd0;
        3'd3: v = (a < b) ? 64'd1 : 64'd0;
        3'd4: v = a ^ b;
        3'd5: begin
          if (up == 0) begin shf = 1; v = a >> sh; end
          else if (up == (1 << (10 - sw))) begin shf = 1; v = 64'(sa >>> sh) & mask; end
          else ill = 1;
        end
        3'd6: v = a | b;
        default: v = a & b;
      endcase
    end else if (o == 7'h1B) begin
      up = int'(i) >> 5;
      sh = int'(i[4:0]);
      if (xlen == 32) ill = 1;
      else begin
        case (f)
          3'd0: v = sx(r[31:0] + b[31:0]);
          3'd1: if (up == 0) begin shf = 1; v = sx(r[31:0] << sh); end else ill = 1;
          3'd5: begin
            if (up == 0) begin shf = 1; v = sx(r[31:0] >> sh); end
            else if (up == 32) begin shf = 1; v = sx($signed(r[31:0]) >>> sh); end
            else ill = 1;
          end
          default: ill = 1;
        endcase
      end
    end else begin
      bub = 1;
    end
    e.ill = ill;
    e.we  = !bub && !ill && (d != 5'd0);
    e.idx = bub ? 5'd0 : d;
    e.val = (bub || ill) ? 64'd0 : v;
    e.lat = (shf && stp > 0 && sh > 0) ? 1 + (sh + stp - 1) / stp : 1;
    return e;
  endfunction

  task automatic gen(output logic [6:0] o, output logic [2:0] f, output logic [63:0] r,
                     output logic [11:0] i, output logic [4:0] d);
    int pick;
    pick = $urandom_range(0, 9);
    o = (pick < 6) ? 7'h13 : (pick < 9) ? 7'h1B : 7'($urandom);
    f = 3'($urandom);
    r = {$urandom, $urandom};
    i = 12'($urandom);
    d = 5'($urandom);
    if (f == 3'd1 || f == 3'd5) begin
      case ($urandom_range(0, 3))
        0: i[11:5] = 7'h00;
        1: i[11:5] = 7'h20;
        2: i[11:6] = 6'h10;
        default: ;
      endcase
    end
  endtask

  task automatic run_one(input bit s, input logic [6:0] o, input logic [2:0] f,
                         input logic [63:0] r, input logic [11:0] i, input logic [4:0] d,
                         input bit use_x, input logic [63:0] xval);
    exp_t e;
    int n;
    e = model(s ? 64 : 32, s ? 0 : 4, o, f, r, i, d);
    @(negedge clk);
    sel = s; op = o; f3 = f; rs1 = r; imm12 = i; rd = d; ordy = 1'b0;
    iv32 = !s; iv64 = s;
    #1 chk("in_ready", o_ir, 1);
    n = 1;
    @(negedge clk);
    while (!o_ov && n < 100) begin
      chk("busy_run", o_bz, e.lat > 1);
      chk("ready_low", o_ir, 0);
      n++;
      @(negedge clk);
    end
    chk("latency", n, e.lat);
    chk("we", o_we, e.we);
    chk("idx", o_ix, e.idx);
    chk("val", o_v, e.val);
    chk("illegal", o_il, e.ill);
    chk("busy_hold", o_bz, 0);
    chk("ready_hold", o_ir, 0);
    if (use_x) chk("plan_val", o_v, xval);
    iv32 = 1'b0; iv64 = 1'b0; ordy = 1'b1;
    #1 chk("ready_drain", o_ir, 1);
    @(negedge clk);
    chk("ov_clear", o_ov, 0);
    ordy = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e, p;
    logic [6:0] go; logic [2:0] gf; logic [63:0] gr; logic [11:0] gi; logic [4:0] gd;
    bit seen;
    rst = 1'b1; iv32 = 0; iv64 = 0; ordy = 0; sel = 0;
    op = 7'h13; f3 = 0; rs1 = 0; imm12 = 0; rd = 0;
    repeat (3) @(negedge clk);
    chk("rst_ready32", ir32, 0);
    chk("rst_ready64", ir64, 0);
    chk("rst_out", {ov32, we32, il32, bz32, ov64, we64, il64, bz64}, 0);
    chk("rst_data", {ix32, v32, ix64, v64}, 0);
    rst = 1'b0;
    #1 chk("post_rst_ready", {ir32, ir64}, 2'b11);

    run_one(0, 7'h13, 3'd0, 64'hFFFF_FFFF, 12'h001, 5'd3, 1, 64'h0);
    run_one(0, 7'h13, 3'd3, 64'd5, 12'hFFF, 5'd1, 1, 64'd1);
    run_one(0, 7'h13, 3'd2, 64'd5, 12'hFFF, 5'd1, 1, 64'd0);
    run_one(0, 7'h13, 3'd5, 64'h8000_0000, 12'h41F, 5'd2, 1, 64'hFFFF_FFFF);
    run_one(0, 7'h13, 3'd5, 64'h1234, 12'h023, 5'd5, 0, 0);
    run_one(0, 7'h13, 3'd6, 64'd5, 12'h0F0, 5'd0, 1, 64'hF5);
    run_one(0, 7'h1B, 3'd0, 64'd1, 12'h001, 5'd4, 0, 0);
    run_one(0, 7'h33, 3'd0, 64'd1, 12'h001, 5'd4, 0, 0);
    run_one(0, 7'h13, 3'd1, 64'h1, 12'h000, 5'd8, 1, 64'h1);
    run_one(1, 7'h1B, 3'd0, 64'h7FFF_FFFF, 12'h001, 5'd6, 1, 64'hFFFF_FFFF_8000_0000);
    run_one(1, 7'h1B, 3'd5, 64'h8000_0000, 12'h404, 5'd7, 1, 64'hFFFF_FFFF_F800_0000);
    run_one(1, 7'h13, 3'd5, 64'h8000_0000_0000_0000, 12'h43F, 5'd9, 1, '1);

    // Backpressure: hold for 5 cycles, then drain and accept together.
    @(negedge clk);
    sel = 0; op = 7'h13; f3 = 3'd0; rs1 = 64'h10; imm12 = 12'h005; rd = 5'd7;
    e = model(32, 4, op, f3, rs1, imm12, rd);
    iv32 = 1; ordy = 0;
    @(negedge clk);
    iv32 = 0;
    for (int k = 0; k < 5; k++) begin
      chk("bp_ov", o_ov, 1);
      chk("bp_val", o_v, e.val);
      chk("bp_idx", o_ix, e.idx);
      chk("bp_we", o_we, e.we);
      chk("bp_ready", o_ir, 0);
      if (k < 4) @(negedge clk);
    end
    f3 = 3'd7; rs1 = 64'hF0F0; imm12 = 12'h0FF; rd = 5'd9;
    e = model(32, 4, op, f3, rs1, imm12, rd);
    iv32 = 1; ordy = 1;
    #1 chk("bp_accept_ready", o_ir, 1);
    @(negedge clk);
    iv32 = 0;
    chk("bp_new_ov", o_ov, 1);
    chk("bp_new_val", o_v, e.val);
    chk("bp_new_idx", o_ix, 9);
    @(negedge clk);
    chk("bp_drained", o_ov, 0);
    ordy = 0;

    // Reset in the middle of an iterative shift.
    @(negedge clk);
    sel = 0; op = 7'h13; f3 = 3'd5; rs1 = 64'h8000_0000; imm12 = 12'h41F; rd = 5'd4;
    iv32 = 1; ordy = 1;
    @(negedge clk);
    iv32 = 0;
    chk("mid_busy", o_bz, 1);
    repeat (2) @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk("mid_rst_out", {o_ov, o_we, o_il, o_bz, o_ir}, 0);
    chk("mid_rst_data", {o_ix, o_v}, 0);
    rst = 0;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (o_ov) seen = 1;
    end
    chk("mid_rst_no_result", seen, 0);
    ordy = 0;

    // Back-to-back single-cycle results on the barrel instance.
    sel = 1; ordy = 1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k > 0) begin
        chk("b2b_ov", o_ov, 1);
        chk("b2b_val", o_v, p.val);
        chk("b2b_idx", o_ix, p.idx);
        chk("b2b_we", o_we, p.we);
      end
      gen(go, gf, gr, gi, gd);
      op = go; f3 = gf; rs1 = gr; imm12 = gi; rd = gd;
      p = model(64, 0, go, gf, gr, gi, gd);
      iv64 = 1;
      #1 chk("b2b_ready", o_ir, 1);
    end
    @(negedge clk);
    iv64 = 0;
    chk("b2b_last_val", o_v, p.val);
    @(negedge clk);
    chk("b2b_end", o_ov, 0);
    ordy = 0;

    for (int k = 0; k < 300; k++) begin
      gen(go, gf, gr, gi, gd);
      run_one(k[0], go, gf, gr, gi, gd, 0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
